// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared definitions for the multicycle RV32I control path:
//               opcode values, controller state encoding, and the mux/ALU/
//               immediate select encodings used by the extender and ALU.
//               The immediate-type helper honours the UTYPE_EN build macro
//               (lui/auipc support).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_UTYPE    = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    // ALUOp (controller -> ALU decoder)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ImmSrc
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA / ALUSrcB
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format for the extender, purely a function of the opcode.
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_SW:             imm = IMM_S;
            OP_BEQ:            imm = IMM_B;
            OP_JAL:            imm = IMM_J;
`ifdef UTYPE_EN
            OP_LUI, OP_AUIPC:  imm = IMM_U;
`else
            OP_LUI, OP_AUIPC:  imm = IMM_I;
`endif
            default:           imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU operation decoder.
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct fields
//   funct3      in  3  IR[14:12]
//   funct7b5    in  1  IR[30]
//   op5         in  1  IR[5] (distinguishes R-type sub from I-type addi)
//   alu_control out 3  ALUControl encoding
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi has no funct7, so IR[30] only means sub for R-type
                    3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore FSM sequencing a multicycle RV32I datapath, with a
//               memory-handshake watchdog that traps to a sticky FAULT state.
//               Build macro UTYPE_EN enables lui/auipc decoding.
// Ports       : clk, reset_n (async active-low); op/funct3/funct7b5 from IR;
//               Zero (ALU); MemReady (memory handshake);
//               PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
//               ALUSrcA, ALUSrcB, ALUControl, ImmSrc (datapath control);
//               IllegalInstr (decode pulse), Fault (sticky trap).
// Parameters  : TIMEOUT_CYCLES - stalled memory cycles tolerated (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       IllegalInstr,
    output logic       Fault
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wd_count;
    logic [1:0]       alu_op;
    logic [2:0]       alu_ctrl;
    logic             mem_state;
    logic             timeout;

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // The counter only reaches the limit after TIMEOUT_CYCLES stalled cycles;
    // from then on the trap wins even if memory finally answers.
    assign timeout   = mem_state && (wd_count == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            wd_count <= '0;
        end else begin
            state <= state_next;
            if (mem_state && !MemReady && (state_next == state))
                wd_count <= wd_count + CNT_W'(1);
            else
                wd_count <= '0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_ctrl)
    );

    assign ALUControl = reset_n ? alu_ctrl : 3'b000;
    assign ImmSrc     = reset_n ? imm_src_for(op) : 3'b000;

    always_comb begin
        state_next   = state;
        alu_op       = ALUOP_ADD;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        IllegalInstr = 1'b0;
        Fault        = 1'b0;

        case (state)
            S_FETCH: begin
                IRWrite   = MemReady && !timeout;
                PCWrite   = MemReady && !timeout;
                ResultSrc = RES_ALURESULT;
                ALUSrcB   = SRCB_FOUR;
                if (timeout)       state_next = S_FAULT;
                else if (MemReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_ITYPE:     state_next = S_EXECI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
`ifdef UTYPE_EN
                    OP_LUI, OP_AUIPC: state_next = S_UTYPE;
`else
                    OP_LUI, OP_AUIPC: begin
                        state_next   = S_FETCH;
                        IllegalInstr = 1'b1;
                    end
`endif
                    default: begin
                        state_next   = S_FETCH;
                        IllegalInstr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (timeout)       state_next = S_FAULT;
                else if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (timeout)       state_next = S_FAULT;
                else if (MemReady) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC <- target held in ALUOut; ALU forms OldPC+4 for rd
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = Zero;
                state_next = S_FETCH;
            end
            S_UTYPE: begin
                // auipc adds the immediate to the instruction's own PC (OldPC);
                // lui goes through the rs1 port, where the datapath supplies x0.
                ALUSrcA    = (op == OP_AUIPC) ? SRCA_OLDPC : SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_FAULT: begin
                Fault = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        if (!reset_n) begin
            PCWrite      = 1'b0;
            AdrSrc       = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            ResultSrc    = 2'b00;
            ALUSrcA      = 2'b00;
            ALUSrcB      = 2'b00;
            IllegalInstr = 1'b0;
            Fault        = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller
//               (TIMEOUT_CYCLES = 4). All controller outputs are packed into
//               one vector and compared against hand-written expectations
//               each cycle. Honours the UTYPE_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic       IllegalInstr, Fault;

    int tests = 0;
    int fails = 0;

    multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .MemReady     (MemReady),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .ImmSrc       (ImmSrc),
        .IllegalInstr (IllegalInstr),
        .Fault        (Fault)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr, Fault};

    function automatic logic [18:0] v(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, sa, sb,
                                      input logic [2:0] alu, imm,
                                      input logic ill, flt);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill, flt};
    endfunction

    // FETCH: PC+4 through the ALU, IR/PC load gated by MemReady
    function automatic logic [18:0] fetch_v(input logic rdy, input logic [2:0] imm);
        return v(rdy, 0, 0, rdy, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
    endfunction

    // DECODE: OldPC + ImmExt
    function automatic logic [18:0] decode_v(input logic [2:0] imm, input logic ill);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill, 0);
    endfunction

    function automatic logic [18:0] aluwb_v(input logic [2:0] imm);
        return v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [18:0] exp);
        #1;
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n  = 1'b0;
        op       = 7'b0100011;   // sw: ImmSrc would be 001 if not held at 0
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        MemReady = 1'b1;
        step();
        chk("reset_all_zero", 19'h0);
        step();
        reset_n = 1'b1;

        // ---- lw, memory ready immediately: 5 cycles ----
        op = 7'b0000011;
        chk("lw_fetch",   fetch_v(1, 3'b000));
        step(); chk("lw_decode",  decode_v(3'b000, 0));
        step(); chk("lw_memadr",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0,0));
        step(); chk("lw_memread", v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0));
        step(); chk("lw_memwb",   v(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0,0));
        step(); chk("lw_back_fetch", fetch_v(1, 3'b000));

        // ---- sw with MemReady low for 3 cycles ----
        op = 7'b0100011;
        chk("sw_fetch", fetch_v(1, 3'b001));
        step(); chk("sw_decode", decode_v(3'b001, 0));
        step(); chk("sw_memadr", v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0,0));
        step();
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sw_memwrite_wait%0d", i),
                v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0,0));
            step();
        end
        MemReady = 1'b1;
        chk("sw_memwrite_done", v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0,0));
        step(); chk("sw_back_fetch", fetch_v(1, 3'b001));

        // ---- beq taken ----
        op = 7'b1100011; Zero = 1'b1;
        step(); chk("beq1_decode", decode_v(3'b010, 0));
        step(); chk("beq_taken", v(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0,0));
        step(); chk("beq1_back_fetch", fetch_v(1, 3'b010));
        // ---- beq not taken ----
        Zero = 1'b0;
        step(); chk("beq0_decode", decode_v(3'b010, 0));
        step(); chk("beq_not_taken", v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0,0));
        step();

        // ---- R-type sub (MemReady ignored outside memory states) ----
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        chk("r_fetch", fetch_v(1, 3'b000));
        step(); MemReady = 1'b0;
        chk("r_decode", decode_v(3'b000, 0));
        step(); chk("r_sub_execr", v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0,0));
        step(); chk("r_aluwb", aluwb_v(3'b000));
        step(); MemReady = 1'b1;
        chk("r_back_fetch", fetch_v(1, 3'b000));

        // ---- I-type addi with IR[30]=1 stays add ----
        op = 7'b0010011;
        step(); step();
        chk("i_add_execi", v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0,0));
        step(); chk("i_aluwb", aluwb_v(3'b000));
        step();

        // ---- R-type and ----
        op = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
        step(); step();
        chk("r_and_execr", v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, 0,0));
        step(); step();

        // ---- jal ----
        op = 7'b1101111; funct3 = 3'b000;
        step(); chk("jal_decode", decode_v(3'b011, 0));
        step(); chk("jal_state", v(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0,0));
        step(); chk("jal_aluwb", aluwb_v(3'b011));
        step(); chk("jal_back_fetch", fetch_v(1, 3'b011));

        // ---- lui ----
        op = 7'b0110111;
`ifdef UTYPE_EN
        step(); chk("lui_decode", decode_v(3'b100, 0));
        step(); chk("lui_utype", v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b100, 0,0));
        step(); chk("lui_aluwb", aluwb_v(3'b100));
        step(); chk("lui_back_fetch", fetch_v(1, 3'b100));
`else
        step(); chk("lui_illegal_decode", decode_v(3'b000, 1));
        step(); chk("lui_back_fetch_no_write", fetch_v(1, 3'b000));
`endif

        // ---- unsupported opcode ----
        op = 7'b1111111;
        step(); chk("bad_op_illegal", decode_v(3'b000, 1));
        step(); chk("bad_op_back_fetch", fetch_v(1, 3'b000));

        // ---- watchdog: MemReady stuck low in FETCH ----
        op = 7'b0110011; MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd_stall%0d", i), fetch_v(0, 3'b000));
            step();
        end
        // limit reached: late MemReady must not rescue the fetch
        MemReady = 1'b1;
        step(); chk("wd_fault", v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,1));
        step(); MemReady = 1'b0;
        chk("wd_fault_sticky", v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,1));
        step(); reset_n = 1'b0;
        chk("fault_reset_zero", 19'h0);
        step(); reset_n = 1'b1; MemReady = 1'b1;
        chk("fault_reset_fetch", fetch_v(1, 3'b000));
        step(); chk("fault_reset_decode", decode_v(3'b000, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
